countdown_timer_p: RTL and testbench

COUNTDOWN_TIMER_P -- requirements
Module: countdown_timer_p

---
 rtl/countdown_timer_p.sv | 198 +++++++++++++++++++
 tb/tb_countdown_timer_p.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_p.sv
// Countdown timer: hr/min/sec/ms counts down on clk_1khz. Fields are set by edge-detected buttons, and start is a run/pause switch.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: on expiry, reload the start value and pulse led instead of stopping.
module countdown_timer_p #(
  parameter int MS_PER_SEC = 1000,
  parameter int MAX_HR     = 23,
  localparam int MS_W      = $clog2(MS_PER_SEC),
  localparam int HR_W      = $clog2(MAX_HR + 1),
  localparam int DIGIT_W   = HR_W + 12 + MS_W
) (
  input  logic               clk_1khz,
  input  logic               reset_in,
  input  logic               start,
  input  logic               hr_inc,
  input  logic               min_inc,
  input  logic               sec_inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               led,
  output logic               running
);

  localparam logic [MS_W-1:0] MS_MAX = MS_W'(MS_PER_SEC - 1);
  localparam logic [HR_W-1:0] HR_MAX = HR_W'(MAX_HR);
  localparam logic [5:0]      SM_MAX = 6'd59;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [HR_W-1:0] r_hr;
  logic [5:0]      r_min;
  logic [5:0]      r_sec;
  logic [MS_W-1:0] r_ms;
  logic            r_led;
  logic            r_running;
  logic            r_hr_d;
  logic            r_min_d;
  logic            r_sec_d;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [DIGIT_W-1:0] r_preset;
`endif

  logic            w_hr_press;
  logic            w_min_press;
  logic            w_sec_press;
  logic            w_any_press;
  logic            w_time_zero;
  logic [HR_W-1:0] w_hr_set;
  logic [5:0]      w_min_set;
  logic [5:0]      w_sec_set;
  logic [MS_W-1:0] w_ms_set;
  logic [HR_W-1:0] w_hr_dec;
  logic [5:0]      w_min_dec;
  logic [5:0]      w_sec_dec;
  logic [MS_W-1:0] w_ms_dec;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_hr_press  = hr_inc  & ~r_hr_d;
    w_min_press = min_inc & ~r_min_d;
    w_sec_press = sec_inc & ~r_sec_d;
    w_any_press = w_hr_press | w_min_press | w_sec_press;
    w_time_zero = (r_hr == '0) && (r_min == '0) && (r_sec == '0) && (r_ms == '0);

    // Each field wraps on its own press; there is no carry between fields.
    w_hr_set  = r_hr;
    w_min_set = r_min;
    w_sec_set = r_sec;
    w_ms_set  = w_any_press ? '0 : r_ms;
    if (w_hr_press)  w_hr_set  = (r_hr  == HR_MAX) ? '0 : r_hr  + 1'b1;
    if (w_min_press) w_min_set = (r_min == SM_MAX) ? '0 : r_min + 1'b1;
    if (w_sec_press) w_sec_set = (r_sec == SM_MAX) ? '0 : r_sec + 1'b1;

    // One tick down. A borrow refills every lower field to its maximum.
    w_hr_dec  = r_hr;
    w_min_dec = r_min;
    w_sec_dec = r_sec;
    w_ms_dec  = r_ms;
    if (r_ms != '0) begin
      w_ms_dec = r_ms - 1'b1;
    end else if (r_sec != '0) begin
      w_sec_dec = r_sec - 1'b1;
      w_ms_dec  = MS_MAX;
    end else if (r_min != '0) begin
      w_min_dec = r_min - 1'b1;
      w_sec_dec = SM_MAX;
      w_ms_dec  = MS_MAX;
    end else if (r_hr != '0) begin
      w_hr_dec  = r_hr - 1'b1;
      w_min_dec = SM_MAX;
      w_sec_dec = SM_MAX;
      w_ms_dec  = MS_MAX;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_1khz) begin
    // NOTE: reset is synchronous and overrides every state; edge detectors clear so a held button counts once.
    if (reset_in) begin
      r_state   <= S_IDLE;
      r_hr      <= '0;
      r_min     <= '0;
      r_sec     <= '0;
      r_ms      <= '0;
      r_led     <= 1'b0;
      r_running <= 1'b0;
      r_hr_d    <= 1'b0;
      r_min_d   <= 1'b0;
      r_sec_d   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_preset  <= '0;
`endif
    end else begin
      r_hr_d  <= hr_inc;
      r_min_d <= min_inc;
      r_sec_d <= sec_inc;

      case (r_state)
        S_IDLE: begin
          r_hr  <= w_hr_set;
          r_min <= w_min_set;
          r_sec <= w_sec_set;
          r_ms  <= w_ms_set;
          r_led <= 1'b0;
          if (start && !w_time_zero) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            r_preset  <= {w_hr_set, w_min_set, w_sec_set, w_ms_set};
`endif
          end
        end

        S_RUN: begin
          if (!start) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
            r_led     <= 1'b0;
          end else if (w_time_zero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            {r_hr, r_min, r_sec, r_ms} <= r_preset;
            r_led                      <= 1'b1;
`else
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_led     <= 1'b1;
`endif
          end else begin
            r_hr  <= w_hr_dec;
            r_min <= w_min_dec;
            r_sec <= w_sec_dec;
            r_ms  <= w_ms_dec;
            r_led <= 1'b0;
          end
        end

        S_PAUSE: begin
          r_hr  <= w_hr_set;
          r_min <= w_min_set;
          r_sec <= w_sec_set;
          r_ms  <= w_ms_set;
          r_led <= 1'b0;
          if (start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end

        S_DONE: begin
          r_hr  <= '0;
          r_min <= '0;
          r_sec <= '0;
          r_ms  <= '0;
          r_led <= 1'b1;
          if (!start) begin
            r_state <= S_IDLE;
            r_led   <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_led     <= 1'b0;
        end
      endcase
    end
  end

  assign digit   = {r_hr, r_min, r_sec, r_ms};
  assign led     = r_led;
  assign running = r_running;

endmodule

// File: tb/tb_countdown_timer_p.sv
// Directed self-checking bench for countdown_timer_p at default parameters (auto-reload macro undefined).
module tb_countdown_timer_p;

  logic        clk_1khz = 1'b0;
  logic        reset_in;
  logic        start;
  logic        hr_inc;
  logic        min_inc;
  logic        sec_inc;
  logic [26:0] digit;
  logic        led;
  logic        running;

  int n_checks = 0;
  int n_errors = 0;

  countdown_timer_p dut (
    .clk_1khz (clk_1khz),
    .reset_in (reset_in),
    .start    (start),
    .hr_inc   (hr_inc),
    .min_inc  (min_inc),
    .sec_inc  (sec_inc),
    .digit    (digit),
    .led      (led),
    .running  (running)
  );

  always #5 clk_1khz = ~clk_1khz;

  function automatic logic [26:0] mk(input int h, input int m, input int s, input int ms);
    return {5'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  task automatic press(input logic h, input logic m, input logic s);
    hr_inc  = h;
    min_inc = m;
    sec_inc = s;
    tick(1);
    hr_inc  = 1'b0;
    min_inc = 1'b0;
    sec_inc = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    tick(1);
    reset_in = 1'b0;
  endtask

  initial begin
    reset_in = 1'b1;
    start    = 1'b0;
    hr_inc   = 1'b0;
    min_inc  = 1'b0;
    sec_inc  = 1'b0;

    // Reset state
    tick(2);
    check("rst_digit",   digit,   mk(0, 0, 0, 0));
    check("rst_led",     led,     1'b0);
    check("rst_running", running, 1'b0);
    reset_in = 1'b0;

    // Seconds wrap 59 -> 0
    for (int i = 0; i < 59; i++) press(0, 0, 1);
    check("sec_59", digit, mk(0, 0, 59, 0));
    press(0, 0, 1);
    check("sec_wrap", digit, mk(0, 0, 0, 0));

    // Minutes wrap 59 -> 0
    for (int i = 0; i < 59; i++) press(0, 1, 0);
    check("min_59", digit, mk(0, 59, 0, 0));
    press(0, 1, 0);
    check("min_wrap", digit, mk(0, 0, 0, 0));

    // Hours wrap MAX_HR -> 0
    for (int i = 0; i < 23; i++) press(1, 0, 0);
    check("hr_23", digit, mk(23, 0, 0, 0));
    press(1, 0, 0);
    check("hr_wrap", digit, mk(0, 0, 0, 0));

    // Simultaneous presses all apply
    press(1, 1, 1);
    check("all_three", digit, mk(1, 1, 1, 0));

    // A button held high counts as exactly one press
    sec_inc = 1'b1;
    tick(4);
    sec_inc = 1'b0;
    tick(1);
    check("held_once", digit, mk(1, 1, 2, 0));

    // A button held high across reset release counts as one press
    sec_inc  = 1'b1;
    reset_in = 1'b1;
    tick(1);
    check("rst_clears", digit, mk(0, 0, 0, 0));
    reset_in = 1'b0;
    tick(1);
    sec_inc = 1'b0;
    tick(1);
    check("press_across_rst", digit, mk(0, 0, 1, 0));

    // Short countdown from sec=1
    start = 1'b1;
    tick(1);
    check("run_entry_running", running, 1'b1);
    check("run_entry_digit",   digit,   mk(0, 0, 1, 0));
    tick(1);
    check("first_dec", digit, mk(0, 0, 0, 999));
    tick(998);
    check("cyc999_digit", digit, mk(0, 0, 0, 1));
    tick(1);
    check("cyc1000_zero",    digit,   mk(0, 0, 0, 0));
    check("cyc1000_led",     led,     1'b0);
    check("cyc1000_running", running, 1'b1);
    tick(1);
    check("cyc1001_led",     led,     1'b1);
    check("cyc1001_running", running, 1'b0);
    press(0, 0, 1);
    check("done_ignores_press", digit, mk(0, 0, 0, 0));
    check("done_led_held",      led,   1'b1);
    start = 1'b0;
    tick(1);
    check("done_exit_led",     led,     1'b0);
    check("done_exit_running", running, 1'b0);

    // Borrow chain from hr=1
    press(1, 0, 0);
    check("borrow_set", digit, mk(1, 0, 0, 0));
    start = 1'b1;
    tick(2);
    check("borrow_chain", digit, mk(0, 59, 59, 999));
    start = 1'b0;
    tick(1);
    check("pause_freeze",   digit,   mk(0, 59, 59, 999));
    check("pause_running",  running, 1'b0);

    // Pause / resume with a set press during PAUSE
    do_reset();
    press(0, 0, 1);
    start = 1'b1;
    tick(1);
    tick(500);
    check("ms_500", digit, mk(0, 0, 0, 500));
    start = 1'b0;
    tick(1);
    check("pause_hold_500", digit, mk(0, 0, 0, 500));
    tick(19);
    check("pause_hold_20",  digit, mk(0, 0, 0, 500));
    press(0, 0, 1);
    check("pause_press", digit, mk(0, 0, 1, 0));
    start = 1'b1;
    tick(1);
    check("resume_running", running, 1'b1);
    check("resume_digit",   digit,   mk(0, 0, 1, 0));
    tick(1);
    check("resume_dec", digit, mk(0, 0, 0, 999));

    // Reset mid-run at min=3; presses in RUN are ignored
    start = 1'b0;
    do_reset();
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    check("min3_set", digit, mk(0, 3, 0, 0));
    start = 1'b1;
    tick(1);
    tick(3);
    press(1, 1, 1);
    check("run_ignores_press", digit, mk(0, 2, 59, 995));
    reset_in = 1'b1;
    tick(1);
    check("midrun_rst_digit",   digit,   mk(0, 0, 0, 0));
    check("midrun_rst_running", running, 1'b0);
    check("midrun_rst_led",     led,     1'b0);
    reset_in = 1'b0;
    tick(3);
    check("zero_start_idle",   running, 1'b0);
    check("zero_start_digit",  digit,   mk(0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
